// File: rtl/pingpong_np_buf.sv
// Two-bank ping-pong buffer: one write port fills a bank while PORT_NUM read ports drain the other.
// Optional sticky protocol/range checker enabled by defining PPBUF_ERR_EN.
module pingpong_np_buf_lane #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] bank,
  output logic [WIDTH-1:0]            data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [WIDTH-1:0] word;

  // Out-of-range addresses read as zero rather than aliasing into the bank.
  always_comb begin
    word = '0;
    if (addr < DEPTH_A) word = bank[addr[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  data <= '0;
    else if (en) data <= word;
  end
endmodule

module pingpong_np_buf #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int PORT_NUM   = 25
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           wr_done,
  output logic                           wr_ready,
  output logic                           wr_bank,
  input  logic                           rd_en,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_np,
  input  logic                           rd_done,
  output logic                           rd_valid,
  output logic                           rd_bank,
  output logic [PORT_NUM*WIDTH-1:0]      rd_data_np,
  output logic                           rd_data_vld,
  output logic                           err,
  input  logic                           err_clr
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [1:0]                        bank_full;
  logic                              wr_sel, rd_sel;
  logic [1:0][DEPTH-1:0][WIDTH-1:0]  mem;
  logic [DEPTH-1:0][WIDTH-1:0]       rd_words;
  logic                              wr_fire, wr_swap, rd_fire, rd_swap;

  assign wr_ready = !bank_full[wr_sel];
  assign rd_valid = bank_full[rd_sel];
  assign wr_bank  = wr_sel;
  assign rd_bank  = rd_sel;

  assign wr_fire = wr_en & wr_ready & (wr_addr < DEPTH_A);
  assign wr_swap = wr_done & wr_ready;
  assign rd_fire = rd_en & rd_valid;
  assign rd_swap = rd_done & rd_valid;

  // wr_ready/rd_valid guarantee the two swaps never target the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      if (wr_swap) begin
        bank_full[wr_sel] <= 1'b1;
        wr_sel            <= ~wr_sel;
      end
      if (rd_swap) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_addr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_vld <= 1'b0;
    else        rd_data_vld <= rd_fire;
  end

  // Pre-swap rd_sel is used, so a read issued with rd_done still sees the old bank.
  assign rd_words = mem[rd_sel];

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_lane
    pingpong_np_buf_lane #(
      .DEPTH      (DEPTH),
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rd_fire),
      .addr  (rd_addr_np[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .bank  (rd_words),
      .data  (rd_data_np[i*WIDTH +: WIDTH])
    );
  end

`ifdef PPBUF_ERR_EN
  logic [PORT_NUM-1:0] rd_oor;
  logic                err_set;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_oor
    assign rd_oor[i] = rd_addr_np[i*ADDR_WIDTH +: ADDR_WIDTH] >= DEPTH_A;
  end

  assign err_set = (wr_en & !wr_ready)
                 | (wr_en & (wr_addr >= DEPTH_A))
                 | (wr_done & !wr_ready)
                 | ((rd_en | rd_done) & !rd_valid)
                 | (rd_fire & (|rd_oor));

  // Set wins over clear so a coincident violation is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pingpong_np_buf.sv
// Directed bench for pingpong_np_buf: reset, fill/read, full-stall, swap, simultaneous swap, range.
module tb_pingpong_np_buf;
  localparam int DEPTH = 32, W = 16, AW = 16, PN = 25;
`ifdef PPBUF_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 0, wr_done = 0, rd_en = 0, rd_done = 0, err_clr = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [PN*AW-1:0] rd_addr_np = '0;
  logic wr_ready, wr_bank, rd_valid, rd_bank, rd_data_vld, err;
  logic [PN*W-1:0] rd_data_np, exp_vec;
  int chk = 0, pass = 0;

  pingpong_np_buf #(.DEPTH(DEPTH), .WIDTH(W), .ADDR_WIDTH(AW), .PORT_NUM(PN)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready), .wr_bank(wr_bank), .rd_en(rd_en),
    .rd_addr_np(rd_addr_np), .rd_done(rd_done), .rd_valid(rd_valid), .rd_bank(rd_bank),
    .rd_data_np(rd_data_np), .rd_data_vld(rd_data_vld), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_bank(input int base);
    wr_en = 1;
    for (int k = 0; k < DEPTH; k++) begin
      wr_addr = AW'(k); wr_data = W'(base + k); tick();
    end
    wr_en = 0;
    wr_done = 1; tick(); wr_done = 0;
  endtask

  task automatic clear_err();
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #12; tick();
    chk++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", wr_ready); else pass++;
    chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else pass++;
    chk++; if (wr_bank !== 1'b0) $display("FAIL reset_wr_bank got %b exp 0", wr_bank); else pass++;
    chk++; if (rd_bank !== 1'b0) $display("FAIL reset_rd_bank got %b exp 0", rd_bank); else pass++;
    chk++; if (rd_data_np !== '0) $display("FAIL reset_rd_data got %h exp 0", rd_data_np); else pass++;
    chk++; if (rd_data_vld !== 1'b0) $display("FAIL reset_rd_vld got %b exp 0", rd_data_vld); else pass++;
    chk++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass++;
    rst_n = 1; tick();
  endtask

  task automatic test_write_read();
    fill_bank(1);
    chk++; if (wr_bank !== 1'b1) $display("FAIL wr_bank_after_done got %b exp 1", wr_bank); else pass++;
    chk++; if (rd_valid !== 1'b1) $display("FAIL rd_valid_after_done got %b exp 1", rd_valid); else pass++;
    chk++; if (wr_ready !== 1'b1) $display("FAIL wr_ready_bank1 got %b exp 1", wr_ready); else pass++;
    for (int i = 0; i < PN; i++) begin
      rd_addr_np[i*AW +: AW] = AW'(i);
      exp_vec[i*W +: W] = W'(i + 1);
    end
    rd_en = 1; tick(); rd_en = 0;
    chk++; if (rd_data_np !== exp_vec) $display("FAIL read_ports got %h exp %h", rd_data_np, exp_vec); else pass++;
    chk++; if (rd_data_vld !== 1'b1) $display("FAIL read_vld got %b exp 1", rd_data_vld); else pass++;
    tick();
    chk++; if (rd_data_vld !== 1'b0) $display("FAIL idle_vld got %b exp 0", rd_data_vld); else pass++;
    chk++; if (rd_data_np !== exp_vec) $display("FAIL hold_data got %h exp %h", rd_data_np, exp_vec); else pass++;
  endtask

  task automatic test_full();
    clear_err();
    fill_bank(100);
    chk++; if (wr_ready !== 1'b0) $display("FAIL both_full_wr_ready got %b exp 0", wr_ready); else pass++;
    chk++; if (wr_bank !== 1'b0) $display("FAIL both_full_wr_bank got %b exp 0", wr_bank); else pass++;
    wr_en = 1; wr_addr = '0; wr_data = 16'hDEAD; tick(); wr_en = 0;
    chk++; if (err !== ERR_EXP) $display("FAIL drop_write_err got %b exp %b", err, ERR_EXP); else pass++;
    rd_addr_np = '0; rd_en = 1; tick(); rd_en = 0;
    chk++; if (rd_data_np[0 +: W] !== 16'd1) $display("FAIL dropped_write_bank0 got %h exp 0001", rd_data_np[0 +: W]); else pass++;
    clear_err();
  endtask

  task automatic test_swap();
    wr_done = 1; rd_done = 1; tick(); wr_done = 0; rd_done = 0;
    chk++; if (rd_bank !== 1'b1) $display("FAIL swap_rd_bank got %b exp 1", rd_bank); else pass++;
    chk++; if (wr_ready !== 1'b1) $display("FAIL swap_wr_ready got %b exp 1", wr_ready); else pass++;
    chk++; if (wr_bank !== 1'b0) $display("FAIL swap_wr_bank got %b exp 0", wr_bank); else pass++;
    rd_addr_np = '0; rd_en = 1;
    wr_en = 1; wr_addr = '0; wr_data = 16'h5555; tick(); wr_en = 0;
    chk++; if (rd_data_np[0 +: W] !== 16'd100) $display("FAIL concurrent_rd got %h exp 0064", rd_data_np[0 +: W]); else pass++;
    tick(); rd_en = 0;
    chk++; if (rd_data_np[0 +: W] !== 16'd100) $display("FAIL post_write_rd got %h exp 0064", rd_data_np[0 +: W]); else pass++;
    clear_err();
  endtask

  task automatic test_simul_swap();
    rd_done = 1; tick(); rd_done = 0;
    chk++; if (rd_bank !== 1'b0) $display("FAIL drain_rd_bank got %b exp 0", rd_bank); else pass++;
    chk++; if (rd_valid !== 1'b0) $display("FAIL drain_rd_valid got %b exp 0", rd_valid); else pass++;
    rd_en = 1; tick(); rd_en = 0;
    chk++; if (rd_data_vld !== 1'b0) $display("FAIL invalid_rd_vld got %b exp 0", rd_data_vld); else pass++;
    fill_bank(200);
    chk++; if (wr_bank !== 1'b1) $display("FAIL refill_wr_bank got %b exp 1", wr_bank); else pass++;
    wr_done = 1; rd_done = 1; tick(); wr_done = 0; rd_done = 0;
    chk++; if (wr_bank !== 1'b0) $display("FAIL simul_wr_bank got %b exp 0", wr_bank); else pass++;
    chk++; if (rd_bank !== 1'b1) $display("FAIL simul_rd_bank got %b exp 1", rd_bank); else pass++;
    chk++; if (rd_valid !== 1'b1) $display("FAIL simul_rd_valid got %b exp 1", rd_valid); else pass++;
    chk++; if (wr_ready !== 1'b1) $display("FAIL simul_wr_ready got %b exp 1", wr_ready); else pass++;
  endtask

  task automatic test_range();
    clear_err();
    rd_addr_np = '0;
    rd_addr_np[0*AW +: AW] = 16'd5;
    rd_addr_np[3*AW +: AW] = 16'd40;
    rd_en = 1; tick(); rd_en = 0;
    chk++; if (rd_data_np[0*W +: W] !== 16'd105) $display("FAIL oor_port0 got %h exp 0069", rd_data_np[0*W +: W]); else pass++;
    chk++; if (rd_data_np[3*W +: W] !== 16'd0) $display("FAIL oor_port3 got %h exp 0000", rd_data_np[3*W +: W]); else pass++;
    chk++; if (rd_data_np[1*W +: W] !== 16'd100) $display("FAIL oor_port1 got %h exp 0064", rd_data_np[1*W +: W]); else pass++;
    chk++; if (err !== ERR_EXP) $display("FAIL oor_err got %b exp %b", err, ERR_EXP); else pass++;
    clear_err();
    chk++; if (err !== 1'b0) $display("FAIL err_clr got %b exp 0", err); else pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_full();
    test_swap();
    test_simul_swap();
    test_range();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
